// File: rtl/decode_scoreboard_pkg.sv
// rtl/decode_scoreboard_pkg.sv - shared opcodes and queue entry type for the decode scoreboard
package decode_scoreboard_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One in-flight writer: destination register and whether it is a load.
  typedef struct packed {
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/decode_scoreboard_sb_queue.sv
// rtl/decode_scoreboard_sb_queue.sv - age-ordered circular FIFO of in-flight destination registers
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         append push_entry at the tail (ignored when full)
//   push_entry   {rd, is_load} of the issuing instruction
//   pop          retire the head entry (ignored when empty)
//   head         oldest entry
//   count        occupancy
//   busy         per-register pending-write vector, bit 0 forced low
module decode_scoreboard_sb_queue
  import decode_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      busy
);

  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head and tail only coincide when empty (no pop) or full (no push), so
  // a simultaneous push and pop never touch the same slot.
  assign do_push = push & (count != CNT_W'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign head    = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      vld      <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_entry;
        vld[tail_ptr] <= 1'b1;
        tail_ptr      <= next_ptr(tail_ptr);
      end
      if (do_pop) begin
        vld[head_ptr] <= 1'b0;
        head_ptr      <= next_ptr(head_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Duplicate rd values simply OR together, so a register stays busy until
  // its youngest writer retires.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i]) busy[mem[i].rd] = 1'b1;
    end
    busy[0] = 1'b0;
  end

endmodule

// File: rtl/decode_scoreboard.sv
// rtl/decode_scoreboard.sv - in-order issue scoreboard sequencing the decode stage
// Optional macro SCOREBOARD_FWD_EN: only load-use hazards stall (forwarding present).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ID_valid_i        ID holds a real instruction
//   ID_instruction_i  instruction in ID (rs1 [19:15], rs2 [24:20], rd [11:7], opcode [6:0])
//   ID_RegWrite_i     instruction writes rd
//   ID_MemRead_i      instruction is a load
//   flush_i           kill the ID instruction this cycle
//   WB_we_i           write-back register write enable
//   WB_wr_addr_i      write-back register address
//   ID_stall_o        hold IF/ID, bubble into EX
//   ID_issue_o        ID instruction advances this cycle
//   busy_o            per-register pending-write vector
//   count_o           queue occupancy
//   err_o             sticky retire-protocol error
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid_i,
  input  logic [31:0]      ID_instruction_i,
  input  logic             ID_RegWrite_i,
  input  logic             ID_MemRead_i,
  input  logic             flush_i,
  input  logic             WB_we_i,
  input  logic [4:0]       WB_wr_addr_i,
  output logic             ID_stall_o,
  output logic             ID_issue_o,
  output logic [31:0]      busy_o,
  output logic [CNT_W-1:0] count_o,
  output logic             err_o
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       use_rs1;
  logic       use_rs2;
  logic       would_push;
  logic       full;
  logic       hazard;
  logic       push;
  logic       retire;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_load;
  sb_entry_t  head;
  logic       unused;

  assign opcode = ID_instruction_i[6:0];
  assign rd     = ID_instruction_i[11:7];
  assign rs1    = ID_instruction_i[19:15];
  assign rs2    = ID_instruction_i[24:20];

  assign use_rs1 = (rs1 != 5'd0) &
                   !((opcode == OPC_LUI) | (opcode == OPC_AUIPC) | (opcode == OPC_JAL));
  assign use_rs2 = (rs2 != 5'd0) &
                   ((opcode == OPC_OP) | (opcode == OPC_STORE) | (opcode == OPC_BRANCH));

  assign would_push = ID_RegWrite_i & (rd != 5'd0);
  // Full is judged on the registered count, so a same-cycle retire does not
  // open a slot for this cycle's issue.
  assign full = would_push & (count_o == CNT_W'(DEPTH));

`ifdef SCOREBOARD_FWD_EN
  // Everything except a load result one stage ahead can be forwarded.
  assign hazard = ex_valid & ex_load & (ex_rd != 5'd0) &
                  ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
  assign unused = ^{ID_instruction_i[31:25], ID_instruction_i[14:12], head.is_load};
`else
  // busy_o is registered, so a retire in this cycle still leaves the bit set.
  assign hazard = (use_rs1 & busy_o[rs1]) | (use_rs2 & busy_o[rs2]);
  assign unused = ^{ID_instruction_i[31:25], ID_instruction_i[14:12], head.is_load,
                    ex_valid, ex_rd, ex_load};
`endif

  assign ID_stall_o = ID_valid_i & !flush_i & (hazard | full);
  assign ID_issue_o = ID_valid_i & !flush_i & !ID_stall_o;
  assign push       = ID_issue_o & would_push;
  assign retire     = WB_we_i & (WB_wr_addr_i != 5'd0);

  decode_scoreboard_sb_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry ('{rd: rd, is_load: ID_MemRead_i}),
    .pop        (retire),
    .head       (head),
    .count      (count_o),
    .busy       (busy_o)
  );

  // EX tracker: a stall or flush loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rd    <= 5'd0;
      ex_load  <= 1'b0;
    end else begin
      ex_valid <= push;
      ex_rd    <= rd;
      ex_load  <= ID_MemRead_i;
    end
  end

  // Retiring into an empty queue or out of order is a protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o <= 1'b0;
    end else if (retire & ((count_o == '0) | (head.rd != WB_wr_addr_i))) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
// tb/tb_decode_scoreboard.sv - directed table-driven bench for decode_scoreboard
module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_valid_i;
  logic [31:0] ID_instruction_i;
  logic        ID_RegWrite_i;
  logic        ID_MemRead_i;
  logic        flush_i;
  logic        WB_we_i;
  logic [4:0]  WB_wr_addr_i;
  logic        ID_stall_o;
  logic        ID_issue_o;
  logic [31:0] busy_o;
  logic [1:0]  count_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_scoreboard #(.DEPTH(3), .CNT_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_valid_i       (ID_valid_i),
    .ID_instruction_i (ID_instruction_i),
    .ID_RegWrite_i    (ID_RegWrite_i),
    .ID_MemRead_i     (ID_MemRead_i),
    .flush_i          (flush_i),
    .WB_we_i          (WB_we_i),
    .WB_wr_addr_i     (WB_wr_addr_i),
    .ID_stall_o       (ID_stall_o),
    .ID_issue_o       (ID_issue_o),
    .busy_o           (busy_o),
    .count_o          (count_o),
    .err_o            (err_o)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] instr;
    logic        rw;
    logic        mr;
    logic        fl;
    logic        we;
    logic [4:0]  wa;
    logic        e_stall;
    logic        e_issue;
    logic [1:0]  e_cnt;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t tv[$];

  function automatic logic [31:0] enc_add(input logic [4:0] rd, rs1, rs2);
    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] SW0    = {7'd0, 5'd0, 5'd0, 3'b010, 5'd0, 7'b0100011};
  // LUI x9 whose immediate happens to hold 7 in the rs1 field.
  localparam logic [31:0] LUI_X9 = {12'h000, 5'd7, 3'b000, 5'd9, 7'b0110111};

  task automatic add(input logic r, v, input logic [31:0] ins, input logic rw, mr, fl, we,
                     input logic [4:0] wa, input logic es, ei, input logic [1:0] ec,
                     input logic [31:0] eb, input logic ee);
    vec_t t;
    t.rst = r; t.valid = v; t.instr = ins; t.rw = rw; t.mr = mr; t.fl = fl;
    t.we = we; t.wa = wa; t.e_stall = es; t.e_issue = ei; t.e_cnt = ec;
    t.e_busy = eb; t.e_err = ee;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, v, input logic [31:0] ins, input logic rw, mr, fl, we,
                       input logic [4:0] wa);
    rst = r; ID_valid_i = v; ID_instruction_i = ins; ID_RegWrite_i = rw;
    ID_MemRead_i = mr; flush_i = fl; WB_we_i = we; WB_wr_addr_i = wa;
  endtask

  // Producer writing x8, then ADD x9,x8,x0 held in ID; x8 retires on the
  // third consumer cycle. Returns the number of stall cycles seen.
  task automatic dep_seq(input logic load_first, input int exp_stalls, input string nm);
    int   stalls = 0;
    logic done = 1'b0;
    @(negedge clk);
    drive(1, 0, NOP, 0, 0, 0, 0, 5'd0);
    repeat (2) @(negedge clk);
    drive(0, 1, load_first ? enc_lw(5'd8, 5'd1) : enc_addi(5'd8, 5'd0, 12'd1), 1, load_first, 0, 0, 5'd0);
    #1 chk({nm, "_producer_issue"}, 0, 32'(ID_issue_o), 32'd1);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      drive(0, 1, enc_add(5'd9, 5'd8, 5'd0), 1, 0, 0, (k == 2), 5'd8);
      #1;
      if (ID_issue_o) done = 1'b1;
      else stalls++;
    end
    chk({nm, "_stall_cycles"}, 0, 32'(stalls), 32'(exp_stalls));
    @(negedge clk);
    drive(0, 0, NOP, 0, 0, 0, 0, 5'd0);
  endtask

  initial begin
    drive(1, 0, NOP, 0, 0, 0, 0, 5'd0);
    repeat (2) @(posedge clk);

`ifndef SCOREBOARD_FWD_EN
    //  rst v  instr                          rw mr fl we wa     st is cnt busy          err
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        0);
    add(0, 1, enc_add(5'd3, 5'd1, 5'd2),      1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 1, 32'h8,        0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd3,  0, 0, 1, 32'h8,        0);
    // RAW on x5
    add(0, 1, enc_addi(5'd5, 5'd0, 12'd1),    1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    add(0, 1, enc_add(5'd6, 5'd5, 5'd5),      1, 0, 0, 0, 5'd0,  1, 0, 1, 32'h20,       0);
    add(0, 1, enc_add(5'd6, 5'd5, 5'd5),      1, 0, 0, 1, 5'd5,  1, 0, 1, 32'h20,       0);
    add(0, 1, enc_add(5'd6, 5'd5, 5'd5),      1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd6,  0, 0, 1, 32'h40,       0);
    // full queue
    add(0, 1, enc_addi(5'd1, 5'd0, 12'd0),    1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    add(0, 1, enc_addi(5'd2, 5'd0, 12'd0),    1, 0, 0, 0, 5'd0,  0, 1, 1, 32'h2,        0);
    add(0, 1, enc_addi(5'd3, 5'd0, 12'd0),    1, 0, 0, 0, 5'd0,  0, 1, 2, 32'h6,        0);
    add(0, 1, enc_addi(5'd4, 5'd0, 12'd0),    1, 0, 0, 0, 5'd0,  1, 0, 3, 32'hE,        0);
    add(0, 1, enc_addi(5'd4, 5'd0, 12'd0),    1, 0, 0, 1, 5'd1,  1, 0, 3, 32'hE,        0);
    add(0, 1, enc_addi(5'd4, 5'd0, 12'd0),    1, 0, 0, 0, 5'd0,  0, 1, 2, 32'hC,        0);
    add(0, 1, SW0,                            0, 0, 0, 0, 5'd0,  0, 1, 3, 32'h1C,       0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd2,  0, 0, 3, 32'h1C,       0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd3,  0, 0, 2, 32'h18,       0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd4,  0, 0, 1, 32'h10,       0);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        0);
    // x0 destination, flush, unused rs1 field
    add(0, 1, enc_addi(5'd0, 5'd0, 12'd5),    1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    add(0, 1, enc_addi(5'd7, 5'd0, 12'd1),    1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    add(0, 1, enc_add(5'd8, 5'd7, 5'd0),      1, 0, 1, 0, 5'd0,  0, 0, 1, 32'h80,       0);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 1, 32'h80,       0);
    add(0, 1, LUI_X9,                         1, 0, 0, 0, 5'd0,  0, 1, 1, 32'h80,       0);
    // out-of-order retire
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd7,  0, 0, 2, 32'h280,      0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd10, 0, 0, 1, 32'h200,      0);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        1);
    // reset mid-traffic
    add(0, 1, enc_addi(5'd11, 5'd0, 12'd1),   1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        1);
    add(1, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 1, 32'h800,      1);
    add(1, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        0);
    add(0, 1, enc_add(5'd3, 5'd1, 5'd2),      1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        0);
    // retire into empty queue
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd3,  0, 0, 1, 32'h8,        0);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd7,  0, 0, 0, 32'h0,        0);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        1);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        1);
    // load-use without forwarding waits for retire
    add(0, 1, enc_lw(5'd8, 5'd1),             1, 1, 0, 0, 5'd0,  0, 1, 0, 32'h0,        1);
    add(0, 1, enc_add(5'd9, 5'd8, 5'd0),      1, 0, 0, 0, 5'd0,  1, 0, 1, 32'h100,      1);
    add(0, 1, enc_add(5'd9, 5'd8, 5'd0),      1, 0, 0, 0, 5'd0,  1, 0, 1, 32'h100,      1);
    add(0, 1, enc_add(5'd9, 5'd8, 5'd0),      1, 0, 0, 1, 5'd8,  1, 0, 1, 32'h100,      1);
    add(0, 1, enc_add(5'd9, 5'd8, 5'd0),      1, 0, 0, 0, 5'd0,  0, 1, 0, 32'h0,        1);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 1, 32'h200,      1);
    add(0, 0, NOP,                            0, 0, 0, 1, 5'd9,  0, 0, 1, 32'h200,      1);
    add(0, 0, NOP,                            0, 0, 0, 0, 5'd0,  0, 0, 0, 32'h0,        1);

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].valid, tv[i].instr, tv[i].rw, tv[i].mr, tv[i].fl, tv[i].we, tv[i].wa);
      #1;
      chk("stall", i, 32'(ID_stall_o), 32'(tv[i].e_stall));
      chk("issue", i, 32'(ID_issue_o), 32'(tv[i].e_issue));
      chk("count", i, 32'(count_o),    32'(tv[i].e_cnt));
      chk("busy",  i, busy_o,          tv[i].e_busy);
      chk("err",   i, 32'(err_o),      32'(tv[i].e_err));
    end
`endif

`ifdef SCOREBOARD_FWD_EN
    dep_seq(1'b1, 1, "load_use");
    dep_seq(1'b0, 0, "alu_use");
`else
    dep_seq(1'b1, 3, "load_use");
    dep_seq(1'b0, 3, "alu_use");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
